// File: rtl/instr_stat_counter.sv
// instr_stat_counter: per-class retired-instruction statistics with saturating counters and registered readout
module instr_stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire_valid,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [31:0]      pc,
  input  logic             freeze,
  input  logic             clear,
  input  logic [3:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             ovf,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FROZEN = 2'd2} state_e;
  localparam logic [CNT_W-1:0] MAX = '1;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [12];
  logic [CNT_W-1:0] cnt_d [12];
  logic [31:0]      last_pc_q, last_pc_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       cls;
  logic             count, tick;
  logic [11:0]      inc;
  always_comb begin
    cls = opcode == 6'd0 ? (funct == 6'd32 ? 4'd0 : funct == 6'd34 ? 4'd1 : funct == 6'd36 ? 4'd2 :
                            funct == 6'd37 ? 4'd3 : funct == 6'd2 ? 4'd4 : 4'd9) :
          opcode == 6'd35 ? 4'd5 : opcode == 6'd43 ? 4'd6 : opcode == 6'd4 ? 4'd7 :
          opcode == 6'd2 ? 4'd8 : 4'd9;
    // the freeze cycle in RUN counts nothing; IDLE only counts the retire that starts RUN
    count = !clear && retire_valid && (state_q == IDLE || (state_q == RUN && !freeze));
    tick  = !clear && ((state_q == IDLE && retire_valid) || (state_q == RUN && !freeze));
    inc   = '0;
    for (int i = 0; i < 10; i++) inc[i] = count && cls == 4'(i);
    inc[10] = count;
    inc[11] = tick;
    ovf_d = ovf_q;
    for (int i = 0; i < 12; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc[i]) begin
        if (cnt_q[i] == MAX) ovf_d = 1'b1;
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
      if (clear) cnt_d[i] = '0;
    end
    if (clear) ovf_d = 1'b0;
    last_pc_d = clear ? 32'd0 : count ? pc : last_pc_q;
    state_d = clear ? IDLE :
              state_q == IDLE && retire_valid ? RUN :
              state_q == RUN && freeze ? FROZEN : state_q;
    rd_data_d = rd_sel < 4'd12 ? cnt_q[rd_sel] : rd_sel == 4'd12 ? CNT_W'(last_pc_q) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '{default: '0};
      last_pc_q <= '0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_pc_q <= last_pc_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
    end
  end
  assign rd_data = rd_data_q;
  assign ovf     = ovf_q;
  assign state   = state_q;
endmodule
